// File: rtl/regfile_pkg.sv
// regfile_pkg: default geometry, address-width helper and data word type for regfile_nr1w
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;
  typedef logic [DEF_DATA_W-1:0] word_t;
  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/regfile_read_mux.sv
// regfile_read_mux: NREGS-to-1, DATA_W-wide combinational register select
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = DEF_NREGS,
  localparam int ADDR_W = addr_w(NREGS)
) (
  input  logic [DATA_W-1:0] i_mem [NREGS],
  input  logic [ADDR_W-1:0] i_sel,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = i_mem[i_sel];
endmodule

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: 1-write, NREAD registered-read register file with write-first bypass
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero (no storage for entry 0).
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS = DEF_NREGS,
  parameter int NREAD = DEF_NREAD,
  localparam int ADDR_W = addr_w(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [NREAD-1:0]        re,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rvalid
);
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  logic [DATA_W-1:0] w_mem [NREGS];
  logic              w_wen;
  assign w_wen = we && !(R0Z && waddr == '0);
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (R0Z && i == 0) begin : g_zero
      assign w_mem[i] = '0;
    end else begin : g_ff
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk)
        if (!reset_n) r_q <= '0;
        else if (w_wen && waddr == ADDR_W'(i)) r_q <= wdata;
      assign w_mem[i] = r_q;
    end
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    assign w_ra = raddr[k*ADDR_W +: ADDR_W];
    regfile_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS)) u_mux (
      .i_mem (w_mem),
      .i_sel (w_ra),
      .o_data(w_sel)
    );
    always_ff @(posedge clk)
      if (!reset_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= re[k];
        if (re[k]) r_data <= (w_wen && waddr == w_ra) ? wdata : w_sel;
      end
    assign rdata[k*DATA_W +: DATA_W] = r_data;
    assign rvalid[k] = r_valid;
  end
endmodule

// File: tb/tb_regfile_nr1w.sv
// tb_regfile_nr1w: directed scoreboard bench for regfile_nr1w (default 32x32, 2 read ports)
module tb_regfile_nr1w;
  import regfile_pkg::*;
  typedef struct {
    logic [1:0] v;
    word_t      d0;
    word_t      d1;
  } exp_t;
`ifdef REGFILE_R0_ZERO_EN
  localparam word_t Z0 = 32'h0;
`else
  localparam word_t Z0 = 32'hFFFFFFFF;
`endif
  logic        clk;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  word_t       wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  regfile_nr1w dut (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rvalid", {30'b0, rvalid}, {30'b0, e.v});
      chk("rdata0", rdata[31:0], e.d0);
      chk("rdata1", rdata[63:32], e.d1);
    end
  end

  task automatic step(input logic rn, input logic w, input logic [4:0] wa, input word_t wd,
                      input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] ev, input word_t e0, input word_t e1);
    exp_t e;
    @(negedge clk);
    reset_n = rn;
    we = w;
    waddr = wa;
    wdata = wd;
    re = r;
    raddr = {ra1, ra0};
    e.v = ev;
    e.d0 = e0;
    e.d1 = e1;
    q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    re = '0;
    raddr = '0;
    // reset dominates a concurrent write
    step(0, 1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0);
    step(0, 1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 2'b01, 5, 0, 2'b01, 32'h0, 32'h0);
    // basic write then read, rvalid pulses once
    step(1, 1, 7, 32'h12345678, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 2'b01, 7, 0, 2'b01, 32'h12345678, 32'h0);
    step(1, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, 32'h12345678, 32'h0);
    // write-first bypass on both ports
    step(1, 1, 3, 32'hAAAA0000, 2'b00, 0, 0, 2'b00, 32'h12345678, 32'h0);
    step(1, 1, 3, 32'h5555FFFF, 2'b11, 3, 3, 2'b11, 32'h5555FFFF, 32'h5555FFFF);
    // hold on port 1 while reg 7 is overwritten
    step(1, 0, 0, 32'h0, 2'b10, 0, 7, 2'b10, 32'h5555FFFF, 32'h12345678);
    for (int i = 0; i < 4; i++)
      step(1, 1, 7, 32'h0, 2'b00, 0, 7, 2'b00, 32'h5555FFFF, 32'h12345678);
    step(1, 0, 0, 32'h0, 2'b11, 7, 3, 2'b11, 32'h0, 32'h5555FFFF);
    // different addresses on each port, no bypass when addresses differ
    step(1, 1, 9, 32'h0BADF00D, 2'b11, 3, 7, 2'b11, 32'h5555FFFF, 32'h0);
    step(1, 0, 0, 32'h0, 2'b11, 9, 9, 2'b11, 32'h0BADF00D, 32'h0BADF00D);
    // reset mid-operation discards the read and clears storage
    step(1, 1, 7, 32'hCAFEBABE, 2'b00, 0, 0, 2'b00, 32'h0BADF00D, 32'h0BADF00D);
    step(0, 0, 0, 32'h0, 2'b01, 7, 0, 2'b00, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 2'b11, 7, 9, 2'b11, 32'h0, 32'h0);
    // register 0: bypass read then plain read
    step(1, 1, 0, 32'hFFFFFFFF, 2'b01, 0, 0, 2'b01, Z0, 32'h0);
    step(1, 0, 0, 32'h0, 2'b10, 0, 0, 2'b10, Z0, Z0);
    step(1, 0, 0, 32'h0, 2'b00, 0, 0, 2'b00, Z0, Z0);
    @(negedge clk);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_nr1w.md
Name: regfile_nr1w

Overview:
Parametrised register file with one write port and NREAD independently enabled, registered read ports. It generalises the fixed 32x32-bit read-select mux into a complete storage-plus-select block: width, depth and read-port count are parameters, and it adds write-first bypass and read-valid strobes. It sits in the CPU decode stage and feeds the operand latches.

Parameters:
DATA_W, 32, bits per register.
NREGS, 32, number of registers; power of two, >= 2.
NREAD, 2, number of read ports; >= 1.
ADDR_W, $clog2(NREGS), address width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
we  input  1  write enable.
waddr  input  ADDR_W  write address.
wdata  input  DATA_W  write data.
re  input  NREAD  per-port read enable.
raddr  input  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
rdata  output  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]; registered.
rvalid  output  NREAD  per-port strobe: rdata for that port was updated this cycle.

Behaviour:
- Reset: on a clk edge with reset_n=0, all NREGS registers go to 0, every rdata field goes to 0, and rvalid goes to 0.
  - Reset dominates: a we or re asserted in the same cycle is ignored.
  - Reset mid-operation discards any read in flight; rvalid is 0 on the following cycle.
- Write: on a clk edge with reset_n=1 and we=1, mem[waddr] <= wdata. There are no write-latency stalls.
- Read latency is 1 cycle.
  - On an edge with re[k]=1: rdata[k] <= mem[raddr[k]] and rvalid[k] <= 1.
  - On an edge with re[k]=0: rdata[k] holds its previous value and rvalid[k] <= 0.
- Write-first bypass: if we=1 and re[k]=1 with raddr[k]==waddr on the same edge, rdata[k] receives wdata, not the old contents.
- Multiple ports may read the same address in the same cycle; each receives identical data.
- Ports are fully independent: no arbitration and no back-pressure.
- Addresses are always in range, because NREGS is a power of two; there is no wrap or error path.
- No combinational path from any input to any output. All outputs come straight from flops.
- Width rules:
  - wdata is stored unmodified.
  - There is no sign extension or truncation.
  - ADDR_W is exactly $clog2(NREGS).

Optional Feature:
Macro: REGFILE_R0_ZERO_EN
- Defined:
  - Register 0 is hardwired to zero; writes to address 0 are discarded.
  - Reads of address 0 return 0, including under bypass with waddr=0.
  - Storage for entry 0 is not instantiated.
- Undefined: register 0 is an ordinary storage entry.

Decomposition:
- Package regfile_pkg holds:
  - the default DATA_W, NREGS and NREAD constants;
  - a function returning ADDR_W from NREGS;
  - a typedef for a DATA_W-wide data word.
- Sub-module regfile_read_mux: a parametrised NREGS-to-1, DATA_W-wide combinational select.
  - One instance per read port, generated over NREAD.
  - Its output drives the bypass compare and then the rdata register.

Test Plan:
- Reset: reset_n=0 for 2 cycles with we=1, waddr=5, wdata=32'hDEADBEEF -> after release, re[0]=1, raddr0=5 gives rdata0=0 and rvalid[0]=1 one cycle later.
- Basic write/read: write 32'h12345678 to reg 7; next cycle re[0]=1, raddr0=7 -> rdata0=32'h12345678 one cycle after the read edge; rvalid[0] is a single-cycle pulse.
- Bypass: reg 3 holds 32'hAAAA0000; same edge we=1, waddr=3, wdata=32'h5555FFFF, re=2'b11, raddr0=raddr1=3 -> both rdata fields = 32'h5555FFFF.
- Hold: after reading 32'h12345678 on port 1, drop re[1] for 4 cycles while writing reg 7 = 0 -> rdata1 stays 32'h12345678 and rvalid[1]=0 throughout.
- Reset mid-operation: re[0]=1, raddr0=7 on the same edge that reset_n=0 -> rdata0=0 and rvalid[0]=0 the next cycle; reg 7 then reads 0.
- REGFILE_R0_ZERO_EN: write 32'hFFFFFFFF to reg 0, with bypass on the same edge and a read one cycle later -> both reads return 0. With the macro undefined, both return 32'hFFFFFFFF.
